// File: rtl/ram_share_arbiter.sv
// Two-requester front end for one simple dual-port distributed RAM.
// Write and read channels are round-robin arbitrated independently; reads return one cycle after accept.
module ram_share_arbiter #(
  parameter int DW = 8,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          a_valid,
  output logic          a_ready,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,

  input  logic          b_valid,
  output logic          b_ready,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,

  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  output logic          ram_we,
  output logic [AW-1:0] ram_dpra,
  input  logic [DW-1:0] ram_dpo
);

  // Handshake: a command transfers in the cycle where valid && ready; the requester
  // keeps valid/we/addr/wdata stable until then. Read responses (rvalid) cannot be stalled.

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_t;

  prio_t wr_prio;
  prio_t rd_prio;

  logic a_rvalid_q;
  logic b_rvalid_q;

  logic a_wr_req;
  logic b_wr_req;
  logic a_rd_req;
  logic b_rd_req;

  logic wr_grant_a;
  logic wr_grant_b;
  logic rd_grant_a;
  logic rd_grant_b;

  // Requests are masked during reset so nothing is granted while rst is high.
  assign a_wr_req = a_valid &  a_we & ~rst;
  assign b_wr_req = b_valid &  b_we & ~rst;
  assign a_rd_req = a_valid & ~a_we & ~rst;
  assign b_rd_req = b_valid & ~b_we & ~rst;

  assign wr_grant_a = a_wr_req & (~b_wr_req | (wr_prio == PRIO_A));
  assign wr_grant_b = b_wr_req & (~a_wr_req | (wr_prio == PRIO_B));
  assign rd_grant_a = a_rd_req & (~b_rd_req | (rd_prio == PRIO_A));
  assign rd_grant_b = b_rd_req & (~a_rd_req | (rd_prio == PRIO_B));

  assign a_ready = wr_grant_a | rd_grant_a;
  assign b_ready = wr_grant_b | rd_grant_b;

  always_comb begin
    ram_we = 1'b0;
    ram_a  = '0;
    ram_d  = '0;
    if (wr_grant_a) begin
      ram_we = 1'b1;
      ram_a  = a_addr;
      ram_d  = a_wdata;
    end else if (wr_grant_b) begin
      ram_we = 1'b1;
      ram_a  = b_addr;
      ram_d  = b_wdata;
    end
  end

  always_comb begin
    ram_dpra = '0;
    if (rd_grant_a) begin
      ram_dpra = a_addr;
    end else if (rd_grant_b) begin
      ram_dpra = b_addr;
    end
  end

  // Read data is sampled before the concurrent write commits, giving read-first behaviour.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_prio    <= PRIO_A;
      rd_prio    <= PRIO_A;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
    end else begin
      if (wr_grant_a) begin
        wr_prio <= PRIO_B;
      end else if (wr_grant_b) begin
        wr_prio <= PRIO_A;
      end

      if (rd_grant_a) begin
        rd_prio <= PRIO_B;
      end else if (rd_grant_b) begin
        rd_prio <= PRIO_A;
      end

      a_rvalid_q <= rd_grant_a;
      b_rvalid_q <= rd_grant_b;
      if (rd_grant_a) begin
        a_rdata <= ram_dpo;
      end
      if (rd_grant_b) begin
        b_rdata <= ram_dpo;
      end
    end
  end

  // A response due in a reset cycle belongs to a read that reset cancels.
  assign a_rvalid = a_rvalid_q & ~rst;
  assign b_rvalid = b_rvalid_q & ~rst;

endmodule

// File: tb/tb_ram_share_arbiter.sv
// Directed bench for ram_share_arbiter with a behavioural distributed RAM attached.
module tb_ram_share_arbiter;

  localparam int DW = 8;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, a_we, a_ready, a_rvalid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          b_valid, b_we, b_ready, b_rvalid;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata, b_rdata;
  logic [AW-1:0] ram_a, ram_dpra;
  logic [DW-1:0] ram_d, ram_dpo;
  logic          ram_we;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ram_share_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we),
    .ram_dpra(ram_dpra), .ram_dpo(ram_dpo)
  );

  // Distributed RAM: write at posedge, asynchronous read.
  assign ram_dpo = mem[ram_dpra];
  always @(posedge clk) begin
    if (ram_we) mem[ram_a] <= ram_d;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic we, input int addr, input int wd);
    a_valid = v;
    a_we    = we;
    a_addr  = AW'(addr);
    a_wdata = DW'(wd);
  endtask

  task automatic set_b(input logic v, input logic we, input int addr, input int wd);
    b_valid = v;
    b_we    = we;
    b_addr  = AW'(addr);
    b_wdata = DW'(wd);
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    set_a(1'b0, 1'b0, 0, 0);
    set_b(1'b0, 1'b0, 0, 0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bit exp_a;
    int ai;
    int bi;

    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[1] = 8'h5A;
    mem[2] = 8'hC3;

    // Reset held 3 cycles with both requesters asserting.
    rst = 1'b1;
    set_a(1'b1, 1'b1, 3, 8'h77);
    set_b(1'b1, 1'b0, 4, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_a_ready", 32'(a_ready), 32'd0);
      check("rst_b_ready", 32'(b_ready), 32'd0);
      check("rst_ram_we", 32'(ram_we), 32'd0);
      check("rst_rvalid", 32'({a_rvalid, b_rvalid}), 32'd0);
    end
    tick();
    rst = 1'b0;
    set_a(1'b0, 1'b0, 0, 0);
    set_b(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    check("rst_a_rdata", 32'(a_rdata), 32'd0);
    check("rst_b_rdata", 32'(b_rdata), 32'd0);
    check("idle_ram_bus", 32'({ram_we, ram_a, ram_d, ram_dpra}), 32'd0);

    // A write then A read of address 5.
    tick();
    set_a(1'b1, 1'b1, 5, 8'h3C);
    @(negedge clk);
    check("wr5_a_ready", 32'(a_ready), 32'd1);
    check("wr5_ram_we", 32'(ram_we), 32'd1);
    check("wr5_ram_a", 32'(ram_a), 32'd5);
    check("wr5_ram_d", 32'(ram_d), 32'h3C);
    tick();
    set_a(1'b1, 1'b0, 5, 0);
    @(negedge clk);
    check("rd5_a_ready", 32'(a_ready), 32'd1);
    check("rd5_dpra", 32'(ram_dpra), 32'd5);
    check("rd5_ram_we", 32'(ram_we), 32'd0);
    tick();
    set_a(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    check("rd5_a_rvalid", 32'(a_rvalid), 32'd1);
    check("rd5_a_rdata", 32'(a_rdata), 32'h3C);
    tick();
    @(negedge clk);
    check("rd5_rvalid_drop", 32'(a_rvalid), 32'd0);
    check("rd5_rdata_hold", 32'(a_rdata), 32'h3C);

    // Both write every cycle; reset first so the write prio starts at A.
    do_reset();
    ai = 0;
    bi = 0;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) tick();
      set_a(1'b1, 1'b1, 16 + ai, 8'hA0 + ai);
      set_b(1'b1, 1'b1, 32 + bi, 8'hB0 + bi);
      @(negedge clk);
      exp_a = (c % 2 == 0);
      check("rr_a_ready", 32'(a_ready), 32'(exp_a));
      check("rr_b_ready", 32'(b_ready), 32'(!exp_a));
      check("rr_ram_a", 32'(ram_a), exp_a ? 32'(16 + ai) : 32'(32 + bi));
      if (exp_a) ai++; else bi++;
    end
    tick();
    set_a(1'b0, 1'b0, 0, 0);
    set_b(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    check("rr_mem16", 32'(mem[16]), 32'hA0);
    check("rr_mem17", 32'(mem[17]), 32'hA1);
    check("rr_mem32", 32'(mem[32]), 32'hB0);
    check("rr_mem33", 32'(mem[33]), 32'hB1);
    check("rr_mem18", 32'(mem[18]), 32'h00);

    // Same-address write and read in one cycle returns the old contents.
    tick();
    set_a(1'b1, 1'b1, 7, 8'h11);
    set_b(1'b1, 1'b0, 7, 0);
    @(negedge clk);
    check("rf_a_ready", 32'(a_ready), 32'd1);
    check("rf_b_ready", 32'(b_ready), 32'd1);
    tick();
    set_a(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    check("rf_b_rvalid_old", 32'(b_rvalid), 32'd1);
    check("rf_b_rdata_old", 32'(b_rdata), 32'h00);
    check("rf_b_ready2", 32'(b_ready), 32'd1);
    tick();
    set_b(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    check("rf_b_rvalid_new", 32'(b_rvalid), 32'd1);
    check("rf_b_rdata_new", 32'(b_rdata), 32'h11);

    // Contended reads with rd prio at A: A first, B next cycle.
    tick();
    set_a(1'b1, 1'b0, 1, 0);
    set_b(1'b1, 1'b0, 2, 0);
    @(negedge clk);
    check("cr_a_ready", 32'(a_ready), 32'd1);
    check("cr_b_ready0", 32'(b_ready), 32'd0);
    check("cr_dpra1", 32'(ram_dpra), 32'd1);
    tick();
    set_a(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    check("cr_b_ready1", 32'(b_ready), 32'd1);
    check("cr_dpra2", 32'(ram_dpra), 32'd2);
    check("cr_a_rvalid", 32'(a_rvalid), 32'd1);
    check("cr_a_rdata", 32'(a_rdata), 32'h5A);
    tick();
    set_b(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    check("cr_b_rvalid", 32'(b_rvalid), 32'd1);
    check("cr_b_rdata", 32'(b_rdata), 32'hC3);
    check("cr_a_rvalid_off", 32'(a_rvalid), 32'd0);

    // Top address write and read from B.
    tick();
    set_b(1'b1, 1'b1, (1 << AW) - 1, 8'hE7);
    @(negedge clk);
    check("top_ram_a", 32'(ram_a), 32'h7FF);
    tick();
    set_b(1'b1, 1'b0, (1 << AW) - 1, 0);
    tick();
    set_b(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    check("top_b_rdata", 32'(b_rdata), 32'hE7);

    // Read accepted, then reset next cycle: response dropped and prio back to A.
    tick();
    set_a(1'b1, 1'b0, 1, 0);
    @(negedge clk);
    check("mr_a_ready", 32'(a_ready), 32'd1);
    tick();
    set_a(1'b0, 1'b0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mr_a_rvalid_rst", 32'(a_rvalid), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mr_a_rvalid_after", 32'(a_rvalid), 32'd0);
    check("mr_a_rdata_cleared", 32'(a_rdata), 32'd0);
    tick();
    set_a(1'b1, 1'b0, 2, 0);
    set_b(1'b1, 1'b0, 1, 0);
    @(negedge clk);
    check("mr_prio_a_ready", 32'(a_ready), 32'd1);
    check("mr_prio_b_ready", 32'(b_ready), 32'd0);
    tick();
    set_a(1'b0, 1'b0, 0, 0);
    set_b(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    check("mr_a_rdata", 32'(a_rdata), 32'hC3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
